// File: rtl/bias_add_17.sv
// bias_add_17: loads N_CH biases per frame, then adds them channel-interleaved to the accumulator stream with saturation.
// Define BIAS_ADD_RELU_EN to clamp negative results to zero after saturation.
module bias_add_17 #(
   parameter int COEFF_W = 16,
   parameter int ACC_W   = 32,
   parameter int N_CH    = 16,
   parameter int N_PIX   = 64
) (
   input  logic               ap_clk,
   input  logic               ap_rst,
   input  logic [COEFF_W-1:0] bias_V_dout,
   input  logic               bias_V_empty_n,
   output logic               bias_V_read,
   input  logic [ACC_W-1:0]   input_V_dout,
   input  logic               input_V_empty_n,
   output logic               input_V_read,
   output logic [ACC_W-1:0]   output_V_din,
   input  logic               output_V_full_n,
   output logic               output_V_write,
   output logic               ap_idle
);
   localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
   localparam int PW = N_PIX > 1 ? $clog2(N_PIX) : 1;
   typedef enum logic {LOAD, RUN} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] ld_cnt_q, ld_cnt_d, ch_cnt_q, ch_cnt_d;
   logic [PW-1:0] pix_cnt_q, pix_cnt_d;
   logic out_vld_q, out_vld_d;
   logic [ACC_W-1:0] dout_q, dout_d, sat, res;
   logic [COEFF_W-1:0] bias_reg [N_CH];
   logic [ACC_W:0] sum;
   logic ld_last, ch_last, pix_last;
   assign ld_last  = ld_cnt_q == CW'(N_CH - 1);
   assign ch_last  = ch_cnt_q == CW'(N_CH - 1);
   assign pix_last = pix_cnt_q == PW'(N_PIX - 1);
   assign sum = {input_V_dout[ACC_W-1], input_V_dout} + (ACC_W+1)'($signed(bias_reg[ch_cnt_q]));
   // the two top sum bits disagree exactly when the result overflowed ACC_W
   assign sat = (sum[ACC_W] != sum[ACC_W-1]) ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
`ifdef BIAS_ADD_RELU_EN
   assign res = sat[ACC_W-1] ? '0 : sat;
`else
   assign res = sat;
`endif
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q   <= LOAD;
         ld_cnt_q  <= '0;
         ch_cnt_q  <= '0;
         pix_cnt_q <= '0;
         out_vld_q <= 1'b0;
         dout_q    <= '0;
      end else begin
         state_q   <= state_d;
         ld_cnt_q  <= ld_cnt_d;
         ch_cnt_q  <= ch_cnt_d;
         pix_cnt_q <= pix_cnt_d;
         out_vld_q <= out_vld_d;
         dout_q    <= dout_d;
      end
   end
   always_ff @(posedge ap_clk) begin
      if (bias_V_read) bias_reg[ld_cnt_q] <= bias_V_dout;
   end
   always_comb begin
      state_d   = state_q;
      ld_cnt_d  = ld_cnt_q;
      ch_cnt_d  = ch_cnt_q;
      pix_cnt_d = pix_cnt_q;
      if (bias_V_read) begin
         ld_cnt_d = ld_last ? '0 : ld_cnt_q + CW'(1);
         state_d  = ld_last ? RUN : LOAD;
      end
      if (input_V_read) begin
         ch_cnt_d  = ch_last ? '0 : ch_cnt_q + CW'(1);
         pix_cnt_d = !ch_last ? pix_cnt_q : pix_last ? '0 : pix_cnt_q + PW'(1);
         state_d   = (ch_last && pix_last) ? LOAD : RUN;
      end
      out_vld_d = input_V_read | (out_vld_q & ~output_V_full_n);
      dout_d    = input_V_read ? res : dout_q;
   end
   always_comb begin
      bias_V_read    = !ap_rst && state_q == LOAD && bias_V_empty_n;
      input_V_read   = !ap_rst && state_q == RUN && input_V_empty_n && (!out_vld_q || output_V_full_n);
      output_V_write = !ap_rst && out_vld_q && output_V_full_n;
      output_V_din   = dout_q;
      ap_idle        = state_q == LOAD && ld_cnt_q == '0 && !out_vld_q;
   end
endmodule

// File: tb/tb_bias_add_17.sv
// tb_bias_add_17: scoreboard bench for bias_add_17 with N_CH=4, N_PIX=2; FIFO models feed the DUT, a monitor checks writes.
module tb_bias_add_17;
   logic ap_clk, ap_rst;
   logic [15:0] bias_V_dout;
   logic bias_V_empty_n, bias_V_read;
   logic [31:0] input_V_dout;
   logic input_V_empty_n, input_V_read;
   logic [31:0] output_V_din;
   logic output_V_full_n, output_V_write, ap_idle;

   bias_add_17 #(.COEFF_W(16), .ACC_W(32), .N_CH(4), .N_PIX(2)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(bias_V_read),
      .input_V_dout(input_V_dout), .input_V_empty_n(input_V_empty_n), .input_V_read(input_V_read),
      .output_V_din(output_V_din), .output_V_full_n(output_V_full_n), .output_V_write(output_V_write),
      .ap_idle(ap_idle)
   );

   int ncmp = 0, nfail = 0;
   int nb = 0, ni = 0, nw = 0, pend = 0, cyc = 0;
   logic [15:0] bq[$];
   logic [31:0] iq[$];
   logic [31:0] exp_q[$];
   logic [15:0] cb [4];
   logic b_pop_f = 0, i_pop_f = 0, bp_en = 0, gap_en = 0, hold_armed = 0;
   logic [31:0] held;

   initial ap_clk = 0;
   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      ncmp++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] a, input logic [15:0] b);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b));
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
`ifdef BIAS_ADD_RELU_EN
      if (s < 0) s = 0;
`endif
      return 32'(s);
   endfunction

   function automatic logic [31:0] c(input int v);
`ifdef BIAS_ADD_RELU_EN
      return v < 0 ? 32'd0 : 32'(v);
`else
      return 32'(v);
`endif
   endfunction

   // FIFO models: pops decided at the negedge are applied just after the next posedge
   initial forever begin
      @(posedge ap_clk);
      #1;
      if (b_pop_f) void'(bq.pop_front());
      if (i_pop_f) void'(iq.pop_front());
      b_pop_f = 0;
      i_pop_f = 0;
      cyc++;
      output_V_full_n = bp_en ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      bias_V_empty_n  = bq.size() > 0;
      bias_V_dout     = bq.size() > 0 ? bq[0] : 16'h0;
      input_V_empty_n = iq.size() > 0 && (!gap_en || cyc % 3 != 0);
      input_V_dout    = iq.size() > 0 ? iq[0] : 32'h0;
   end

   initial forever begin
      @(negedge ap_clk);
      if (!output_V_full_n) chk("write_while_full", output_V_write, 1'b0);
      if (hold_armed) chk("din_hold", output_V_din, held);
      hold_armed = pend > 0 && !output_V_full_n && !ap_rst;
      held = output_V_din;
      if (output_V_write) begin
         if (exp_q.size() == 0) chk("unexpected_write", output_V_din, 32'hx);
         else chk("out", output_V_din, exp_q.pop_front());
         nw++;
         pend--;
      end
      if (input_V_read) begin
         ni++;
         pend++;
      end
      if (bias_V_read) nb++;
      b_pop_f = bias_V_read;
      i_pop_f = input_V_read;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(negedge ap_clk);
      #1;
   endtask

   task automatic set_bias(input int b0, input int b1, input int b2, input int b3);
      cb[0] = 16'(b0); cb[1] = 16'(b1); cb[2] = 16'(b2); cb[3] = 16'(b3);
      for (int i = 0; i < 4; i++) bq.push_back(cb[i]);
   endtask

   task automatic push_model(input logic [31:0] x [8]);
      for (int i = 0; i < 8; i++) begin
         iq.push_back(x[i]);
         exp_q.push_back(model(x[i], cb[i % 4]));
      end
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while ((exp_q.size() != 0 || pend != 0 || iq.size() != 0) && k < 300) begin
         tick();
         k++;
      end
      chk(tag, 32'(k < 300), 32'd1);
      repeat (2) tick();
   endtask

   task automatic do_reset();
      @(posedge ap_clk);
      #2;
      ap_rst = 1;
      bq.delete();
      iq.delete();
      exp_q.delete();
      pend = 0;
      tick();
      chk("rst_bias_read", bias_V_read, 1'b0);
      chk("rst_input_read", input_V_read, 1'b0);
      chk("rst_write", output_V_write, 1'b0);
      @(posedge ap_clk);
      #2;
      ap_rst = 0;
      tick();
      chk("rst_din", output_V_din, 32'd0);
      chk("rst_write_after", output_V_write, 1'b0);
      chk("rst_idle", ap_idle, 1'b1);
   endtask

   initial begin
      logic [31:0] x [8];
      int nb0, ni0, nw0, k;
      ap_rst = 1;
      bias_V_empty_n = 0; bias_V_dout = 0;
      input_V_empty_n = 0; input_V_dout = 0;
      output_V_full_n = 1;
      tick();
      chk("init_bias_read", bias_V_read, 1'b0);
      chk("init_input_read", input_V_read, 1'b0);
      chk("init_write", output_V_write, 1'b0);
      @(posedge ap_clk);
      #2;
      ap_rst = 0;
      tick();
      chk("init_idle", ap_idle, 1'b1);
      chk("init_din", output_V_din, 32'd0);

      // basic frame
      nb0 = nb; ni0 = ni; nw0 = nw;
      set_bias(1, -2, 3, -4);
      for (int i = 0; i < 8; i++) iq.push_back(32'(i));
      foreach (x[i]) x[i] = 0;
      exp_q.push_back(c(1)); exp_q.push_back(c(-1)); exp_q.push_back(c(5)); exp_q.push_back(c(-1));
      exp_q.push_back(c(5)); exp_q.push_back(c(3)); exp_q.push_back(c(9)); exp_q.push_back(c(3));
      k = 0;
      while (nb - nb0 < 4 && k < 50) begin tick(); k++; end
      chk("basic_load_done", 32'(nb - nb0), 32'd4);
      chk("basic_no_input_in_load", 32'(ni - ni0), 32'd0);
      drain("basic_drain");
      chk("basic_bias_pops", 32'(nb - nb0), 32'd4);
      chk("basic_input_pops", 32'(ni - ni0), 32'd8);
      chk("basic_writes", 32'(nw - nw0), 32'd8);
      chk("basic_idle", ap_idle, 1'b1);

      // saturation and fused-ReLU corner
      set_bias(16'h7FFF, -32768, 2, 0);
      iq.push_back(32'h7FFFFFF0); exp_q.push_back(32'h7FFFFFFF);
      iq.push_back(32'h80000005); exp_q.push_back(c(32'h80000000));
      iq.push_back(32'hFFFFFFFB); exp_q.push_back(c(-3));
      iq.push_back(32'd100);      exp_q.push_back(c(100));
      iq.push_back(32'hFFFFFFFF); exp_q.push_back(32'h00007FFE);
      iq.push_back(32'h7FFFFFFF); exp_q.push_back(32'h7FFF7FFF);
      iq.push_back(32'd3);        exp_q.push_back(c(5));
      iq.push_back(32'hFFFFFFF9); exp_q.push_back(c(-7));
      drain("sat_drain");

      // back-pressure 1,0,0,1 over a full frame
      bp_en = 1;
      set_bias(-100, 200, 32767, -32768);
      foreach (x[i]) x[i] = $urandom;
      push_model(x);
      drain("bp_drain");
      bp_en = 0;
      repeat (2) tick();

      // starved bias FIFO mid-LOAD, gapped input, then a back-to-back frame
      gap_en = 1;
      foreach (x[i]) x[i] = 32'(i * 7 - 20);
      nb0 = nb;
      cb[0] = 10; cb[1] = 20; cb[2] = 30; cb[3] = 40;
      push_model(x);
      bq.push_back(16'd10); bq.push_back(16'd20);
      k = 0;
      while (nb - nb0 < 2 && k < 50) begin tick(); k++; end
      chk("starve_partial_load", 32'(nb - nb0), 32'd2);
      ni0 = ni;
      repeat (10) tick();
      chk("starve_no_input_pop", 32'(ni - ni0), 32'd0);
      bq.push_back(16'd30); bq.push_back(16'd40);
      set_bias(-1, -1, -1, -1);
      foreach (x[i]) x[i] = 32'(i * 1000 - 3);
      push_model(x);
      drain("b2b_drain");
      gap_en = 0;
      chk("b2b_bias_pops", 32'(nb - nb0), 32'd8);

      // reset mid-frame, then a clean frame
      set_bias(1, 1, 1, 1);
      foreach (x[i]) x[i] = 32'(i + 50);
      push_model(x);
      nw0 = nw;
      k = 0;
      while (nw - nw0 < 3 && k < 50) begin tick(); k++; end
      chk("pre_reset_writes", 32'(nw - nw0 >= 3), 32'd1);
      do_reset();
      set_bias(5, 6, 7, -8);
      foreach (x[i]) x[i] = 32'(i * 3 - 9);
      push_model(x);
      drain("restart_drain");
      chk("final_idle", ap_idle, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
